// File: rtl/dict_loader.sv
// Boot-time dictionary loader: fetches a header plus tagged entry words from
// instruction memory and streams each entry into the fetch controller's dictionaries.
module dict_loader #(
   parameter int unsigned FIELD1_KEY_WIDTH = 3,
   parameter int unsigned FIELD2_KEY_WIDTH = 8,
   parameter int unsigned FIELD3_KEY_WIDTH = 5,
   parameter int unsigned FIELD1_VAL_WIDTH = 7,
   parameter int unsigned FIELD2_VAL_WIDTH = 15,
   parameter int unsigned FIELD3_VAL_WIDTH = 10,
   parameter logic [31:0] DICT_BASE_ADDR   = 32'h0000_1000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic                        mem_req_valid,
   input  logic                        mem_req_ready,
   output logic [31:0]                 mem_req_addr,
   input  logic [31:0]                 mem_req_rdata,
   output logic                        dict1_write_enable,
   output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
   output logic                        dict2_write_enable,
   output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
   output logic                        dict3_write_enable,
   output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val
);

   localparam logic [31:0] CAP1 = 32'd1 << FIELD1_KEY_WIDTH;
   localparam logic [31:0] CAP2 = 32'd1 << FIELD2_KEY_WIDTH;
   localparam logic [31:0] CAP3 = 32'd1 << FIELD3_KEY_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_ENTRY,
      S_WR,
      S_DONE,
      S_ERR
   } state_t;

   // Field codes equal the entry tag that selects them.
   typedef enum logic [1:0] {
      F_NONE = 2'b00,
      F_D1   = 2'b01,
      F_D2   = 2'b10,
      F_D3   = 2'b11
   } field_t;

   state_t                      state_q;
   field_t                      field_q;
   logic [31:0]                 addr_q;
   logic                        valid_q;
   logic                        busy_q;
   logic                        done_q;
   logic                        error_q;
   logic [3:0]                  cnt1_q;
   logic [8:0]                  cnt2_q;
   logic [5:0]                  cnt3_q;
   logic                        we1_q;
   logic                        we2_q;
   logic                        we3_q;
   logic [FIELD1_VAL_WIDTH-1:0] val1_q;
   logic [FIELD2_VAL_WIDTH-1:0] val2_q;
   logic [FIELD3_VAL_WIDTH-1:0] val3_q;

   logic [3:0]                  hdr_n1_d;
   logic [8:0]                  hdr_n2_d;
   logic [5:0]                  hdr_n3_d;
   logic                        hdr_bad_d;
   field_t                      hdr_first_d;
   logic                        entry_pad_ok_d;
   logic                        entry_ok_d;
   field_t                      wr_next_d;

   function automatic field_t first_field(input logic [3:0] c1,
                                          input logic [8:0] c2,
                                          input logic [5:0] c3);
      field_t f;
      f = F_NONE;
      if (c1 != '0)      f = F_D1;
      else if (c2 != '0) f = F_D2;
      else if (c3 != '0) f = F_D3;
      return f;
   endfunction

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no latch is inferred.
      hdr_n1_d       = mem_req_rdata[3:0];
      hdr_n2_d       = mem_req_rdata[12:4];
      hdr_n3_d       = mem_req_rdata[18:13];
      hdr_bad_d      = (mem_req_rdata[31:19] != '0)
                     || ({28'd0, hdr_n1_d} > CAP1)
                     || ({23'd0, hdr_n2_d} > CAP2)
                     || ({26'd0, hdr_n3_d} > CAP3);
      hdr_first_d    = first_field(hdr_n1_d, hdr_n2_d, hdr_n3_d);
      entry_pad_ok_d = 1'b0;
      case (field_q)
         F_D1:    entry_pad_ok_d = ((mem_req_rdata[29:0] >> FIELD1_VAL_WIDTH) == '0);
         F_D2:    entry_pad_ok_d = ((mem_req_rdata[29:0] >> FIELD2_VAL_WIDTH) == '0);
         F_D3:    entry_pad_ok_d = ((mem_req_rdata[29:0] >> FIELD3_VAL_WIDTH) == '0);
         default: entry_pad_ok_d = 1'b0;
      endcase
      entry_ok_d     = (mem_req_rdata[31:30] == field_q) && entry_pad_ok_d;
      // Counts are already decremented in WR, so the first nonzero field is
      // either the current one (entries remain) or the next populated one.
      wr_next_d      = first_field(cnt1_q, cnt2_q, cnt3_q);
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         field_q <= F_NONE;
         addr_q  <= DICT_BASE_ADDR;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         cnt1_q  <= '0;
         cnt2_q  <= '0;
         cnt3_q  <= '0;
         we1_q   <= 1'b0;
         we2_q   <= 1'b0;
         we3_q   <= 1'b0;
         val1_q  <= '0;
         val2_q  <= '0;
         val3_q  <= '0;
      end else begin
         we1_q <= 1'b0;
         we2_q <= 1'b0;
         we3_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state_q <= S_HDR;
                  addr_q  <= DICT_BASE_ADDR;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  error_q <= 1'b0;
               end
            end

            S_HDR: begin
               if (mem_req_ready) begin
                  valid_q <= 1'b0;
                  if (hdr_bad_d) begin
                     state_q <= S_ERR;
                     busy_q  <= 1'b0;
                     error_q <= 1'b1;
                  end else if (hdr_first_d == F_NONE) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_ENTRY;
                     addr_q  <= addr_q + 32'd4;
                     cnt1_q  <= hdr_n1_d;
                     cnt2_q  <= hdr_n2_d;
                     cnt3_q  <= hdr_n3_d;
                     field_q <= hdr_first_d;
                  end
               end
            end

            S_ENTRY: begin
               // Entered with valid low after the header; the request rises one
               // cycle later so valid always drops for a cycle between requests.
               if (!valid_q) begin
                  valid_q <= 1'b1;
               end else if (mem_req_ready) begin
                  valid_q <= 1'b0;
                  if (!entry_ok_d) begin
                     state_q <= S_ERR;
                     busy_q  <= 1'b0;
                     error_q <= 1'b1;
                  end else begin
                     state_q <= S_WR;
                     case (field_q)
                        F_D1: begin
                           cnt1_q <= cnt1_q - 4'd1;
                           we1_q  <= 1'b1;
                           val1_q <= mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
                        end
                        F_D2: begin
                           cnt2_q <= cnt2_q - 9'd1;
                           we2_q  <= 1'b1;
                           val2_q <= mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
                        end
                        F_D3: begin
                           cnt3_q <= cnt3_q - 6'd1;
                           we3_q  <= 1'b1;
                           val3_q <= mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
                        end
                        default: begin
                           state_q <= S_ERR;
                           busy_q  <= 1'b0;
                           error_q <= 1'b1;
                        end
                     endcase
                  end
               end
            end

            S_WR: begin
               if (wr_next_d == F_NONE) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_ENTRY;
                  field_q <= wr_next_d;
                  addr_q  <= addr_q + 32'd4;
                  valid_q <= 1'b1;
               end
            end

            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy               = busy_q;
   assign done               = done_q;
   assign error              = error_q;
   assign mem_req_valid      = valid_q;
   assign mem_req_addr       = addr_q;
   assign dict1_write_enable = we1_q;
   assign dict1_write_val    = val1_q;
   assign dict2_write_enable = we2_q;
   assign dict2_write_val    = val2_q;
   assign dict3_write_enable = we3_q;
   assign dict3_write_val    = val3_q;

endmodule
